// File: rtl/md_ctrl.sv
// md_ctrl: multi-cycle multiply/divide controller owning HI/LO with fixed-latency busy
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [CW-1:0] count, count_n;
  logic [31:0] pend_hi, pend_lo, pend_hi_n, pend_lo_n, hi_n, lo_n;
  logic pend_we, pend_we_n;
  logic signed [63:0] sprod;
  logic [63:0] uprod;
  logic [31:0] abs_a, abs_b, div_b, uq, ur, sq, sr, dq, dr;
  assign sprod = $signed(A) * $signed(B);
  assign uprod = {32'b0, A} * {32'b0, B};
  // Signed divide goes through magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000
  assign abs_a = (op == 3'd2 && A[31]) ? -A : A;
  assign abs_b = (op == 3'd2 && B[31]) ? -B : B;
  assign div_b = (abs_b == 32'b0) ? 32'd1 : abs_b;
  assign uq = abs_a / div_b;
  assign ur = abs_a % div_b;
  assign sq = (A[31] ^ B[31]) ? -uq : uq;
  assign sr = A[31] ? -ur : ur;
  assign dq = (op == 3'd2) ? sq : uq;
  assign dr = (op == 3'd2) ? sr : ur;
  assign busy = (state == RUN);
  always_comb begin
    state_n   = state;
    count_n   = count;
    pend_hi_n = pend_hi;
    pend_lo_n = pend_lo;
    pend_we_n = pend_we;
    hi_n      = HI;
    lo_n      = LO;
    if (state == IDLE) begin
      if (start && op <= 3'd3) begin
        state_n   = RUN;
        count_n   = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        pend_hi_n = op[1] ? dr : (op[0] ? uprod[63:32] : sprod[63:32]);
        pend_lo_n = op[1] ? dq : (op[0] ? uprod[31:0] : sprod[31:0]);
        pend_we_n = !(op[1] && B == 32'b0);
      end else if (start && op == 3'd4) begin
        hi_n = A;
      end else if (start && op == 3'd5) begin
        lo_n = A;
      end
    end else begin
      count_n = count - CW'(1);
      if (count == CW'(1)) begin
        state_n = IDLE;
        hi_n    = pend_we ? pend_hi : HI;
        lo_n    = pend_we ? pend_lo : LO;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_we <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      pend_hi <= pend_hi_n;
      pend_lo <= pend_lo_n;
      pend_we <= pend_we_n;
      HI      <= hi_n;
      LO      <= lo_n;
    end
  end
endmodule
